qdma_fifo_crdt_arb: RTL and testbench

Credit arbiter that shares the credit interface of one QDMA staging FIFO (crdt_req / crdt_req_cnt / crdt_gnt / crdt) among NUM_REQ upstream requesters. It picks one requester at a time in round-robin order and forwards its credit request to the FIFO. It routes the grant back to that requester and caps each requester's outstanding (granted but not yet consumed) credits. It sits between the C2H/H2C producers and the FIFO credit port.

---
 rtl/qdma_fifo_crdt_arb_pkg.sv | 17 +
 rtl/qdma_fifo_crdt_arb_if.sv | 34 +++
 rtl/qdma_rr_pick.sv | 29 ++
 rtl/qdma_fifo_crdt_arb.sv | 125 ++++++++++++
 tb/tb_qdma_fifo_crdt_arb.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qdma_fifo_crdt_arb_pkg.sv
// Shared types and helpers for the QDMA staging-FIFO credit arbiter.
package qdma_fifo_crdt_arb_pkg;

  // ARB: look for an eligible requester; ISSUE: hold the credit request until the FIFO grants.
  typedef enum logic {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } crdt_arb_st_e;

  // Circular index step: (idx + off) mod n.
  function automatic int unsigned circ_add(input int unsigned idx,
                                           input int unsigned off,
                                           input int unsigned n);
    return (idx + off) % n;
  endfunction

endpackage

// File: rtl/qdma_fifo_crdt_arb_if.sv
// Credit-request bus between the requesters, the arbiter and the staging FIFO.
//
// Handshake: a requester raises req_vld[i] with req_cnt[i] and holds both until
// req_gnt[i] pulses; the arbiter raises fifo_crdt_req with fifo_crdt_req_cnt and
// holds both until fifo_crdt_gnt is high. A transfer completes in the cycle where
// fifo_crdt_req and fifo_crdt_gnt are both high, and req_gnt is that same cycle.
// cons_vld/cons_cnt are single-cycle notifications with no back-pressure.
interface qdma_fifo_crdt_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 2,
  parameter int CRDT_W  = 3
);
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*CNT_W-1:0] req_cnt;
  logic [NUM_REQ-1:0]       req_gnt;
  logic [NUM_REQ-1:0]       cons_vld;
  logic [NUM_REQ*CNT_W-1:0] cons_cnt;
  logic                     fifo_crdt_req;
  logic [CNT_W-1:0]         fifo_crdt_req_cnt;
  logic                     fifo_crdt_gnt;
  logic [CRDT_W-1:0]        fifo_crdt;

  // Arbiter side.
  modport master (
    input  req_vld, req_cnt, cons_vld, cons_cnt, fifo_crdt_gnt, fifo_crdt,
    output req_gnt, fifo_crdt_req, fifo_crdt_req_cnt
  );

  // Requester / FIFO side.
  modport slave (
    output req_vld, req_cnt, cons_vld, cons_cnt, fifo_crdt_gnt, fifo_crdt,
    input  req_gnt, fifo_crdt_req, fifo_crdt_req_cnt
  );
endinterface

// File: rtl/qdma_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after rr_ptr.
module qdma_rr_pick
  import qdma_fifo_crdt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               win_vld,
  output logic [IDX_W-1:0]   win_idx
);

  // Scan circularly from rr_ptr and keep the first eligible index.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'(circ_add(32'(rr_ptr), k, NUM_REQ));
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/qdma_fifo_crdt_arb.sv
// Round-robin credit arbiter sharing one QDMA staging-FIFO credit port among
// NUM_REQ requesters, with a per-requester cap on outstanding credits.
module qdma_fifo_crdt_arb
  import qdma_fifo_crdt_arb_pkg::*;
#(
  parameter int TCQ        = 1,
  parameter int NUM_REQ    = 4,
  parameter int CNT_W      = 2,
  parameter int CRDT_W     = 3,
  parameter int MAX_OUTSTD = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  qdma_fifo_crdt_arb_if.master        bus,
  output logic [NUM_REQ*CRDT_W-1:0]   outstd,
  output crdt_arb_st_e                fsm_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // TCQ only exists for simulation-delay flows; registers here carry no delay.
  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_OUTSTD > (2**CRDT_W) - 1 || TCQ < 0) begin : g_param_err
    $error("qdma_fifo_crdt_arb: illegal parameter set");
  end

  crdt_arb_st_e       state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   win_cnt;
  logic               err_undf;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] undf_hit;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [CNT_W-1:0]   pick_cnt;
  logic               gnt_fire;

  assign gnt_fire  = (state == ISSUE) && bus.fifo_crdt_gnt;
  assign fsm_state = state;

  // Per-requester eligibility and outstanding-credit counter.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic [CRDT_W-1:0] cnt_q;
    logic [CNT_W-1:0]  rc;
    logic [CRDT_W:0]   rc_x;
    logic [CRDT_W:0]   base_x;
    logic [CRDT_W:0]   sub_x;

    assign rc      = bus.req_cnt[g*CNT_W +: CNT_W];
    assign rc_x    = (CRDT_W+1)'(rc);
    assign elig[g] = bus.req_vld[g] && (rc != '0)
                     && (({1'b0, cnt_q} + rc_x) <= (CRDT_W+1)'(MAX_OUTSTD))
                     && (rc_x <= {1'b0, bus.fifo_crdt});

    // Grant adds and consume subtracts in the same cycle; underflow clamps at 0.
    assign base_x      = {1'b0, cnt_q}
                         + ((gnt_fire && (win_idx == IDX_W'(g))) ? (CRDT_W+1)'(win_cnt) : '0);
    assign sub_x       = bus.cons_vld[g] ? (CRDT_W+1)'(bus.cons_cnt[g*CNT_W +: CNT_W]) : '0;
    assign undf_hit[g] = base_x < sub_x;

    // Outstanding credits for requester g.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= undf_hit[g] ? '0 : CRDT_W'(base_x - sub_x);
    end

    assign outstd[g*CRDT_W +: CRDT_W] = cnt_q;
  end

  qdma_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .elig    (elig),
    .rr_ptr  (rr_ptr),
    .win_vld (pick_vld),
    .win_idx (pick_idx)
  );

  // Select the request count of the picked requester.
  always_comb begin
    pick_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_cnt = bus.req_cnt[i*CNT_W +: CNT_W];
    end
  end

  // Arbitration FSM: latch the winner in ARB, wait for the FIFO grant in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      rr_ptr  <= '0;
      win_idx <= '0;
      win_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (pick_vld) begin
            win_idx <= pick_idx;
            win_cnt <= pick_cnt;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.fifo_crdt_gnt) begin
            rr_ptr <= IDX_W'(circ_add(32'(win_idx), 1, NUM_REQ));
            state  <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Sticky record that a consume exceeded the outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_undf <= 1'b0;
    else        err_undf <= err_undf | (|undf_hit);
  end

  assign bus.fifo_crdt_req     = (state == ISSUE);
  assign bus.fifo_crdt_req_cnt = (state == ISSUE) ? win_cnt : '0;
  assign bus.req_gnt           = gnt_fire ? (NUM_REQ'(1) << win_idx) : '0;

endmodule

// File: tb/tb_qdma_fifo_crdt_arb.sv
// Directed bench for qdma_fifo_crdt_arb with a grant scoreboard.
module tb_qdma_fifo_crdt_arb;
  import qdma_fifo_crdt_arb_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int CNT_W      = 2;
  localparam int CRDT_W     = 3;
  localparam int MAX_OUTSTD = 4;
  localparam int W          = NUM_REQ + CNT_W;

  logic clk;
  logic rst_n;
  logic [NUM_REQ*CRDT_W-1:0] outstd;
  crdt_arb_st_e fsm_state;

  qdma_fifo_crdt_arb_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .CRDT_W(CRDT_W)) bus ();

  qdma_fifo_crdt_arb #(
    .TCQ(1), .NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .CRDT_W(CRDT_W), .MAX_OUTSTD(MAX_OUTSTD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .outstd    (outstd),
    .fsm_state (fsm_state)
  );

  // Scoreboard: {req_gnt vector, granted count} per expected grant, in order.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NUM_REQ*CNT_W-1:0] pack(input int c0, input int c1,
                                                    input int c2, input int c3);
    return {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
  endfunction

  function automatic logic [CRDT_W-1:0] outstd_of(input int i);
    return outstd[i*CRDT_W +: CRDT_W];
  endfunction

  // Inputs change just after the active edge; outputs are checked on the falling edge.
  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_vld       = '0;
    bus.req_cnt       = '0;
    bus.cons_vld      = '0;
    bus.cons_cnt      = '0;
    bus.fifo_crdt_gnt = 1'b0;
    bus.fifo_crdt     = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    mid();
    check("rst_fifo_req", bus.fifo_crdt_req, 0);
    check("rst_fifo_cnt", bus.fifo_crdt_req_cnt, 0);
    check("rst_req_gnt", bus.req_gnt, 0);
    check("rst_outstd", outstd, 0);
    check("rst_state", fsm_state, ARB);
    check("rst_rr_ptr", dut.rr_ptr, 0);
    check("rst_win_idx", dut.win_idx, 0);
    check("rst_win_cnt", dut.win_cnt, 0);
    check("rst_err_undf", dut.err_undf, 0);
    rst_n = 1'b1;
    cyc_start();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && bus.req_gnt != '0) begin
      if (exp_q.size() == 0) begin
        check("gnt_unexpected", bus.req_gnt, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_gnt_vec", bus.req_gnt, e[W-1:CNT_W]);
        check("sb_gnt_cnt", bus.fifo_crdt_req_cnt, e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: bench did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [NUM_REQ-1:0] e_gnt;
    rst_n = 1'b0;
    idle_inputs();

    // Single requester, immediate grant.
    apply_reset();
    bus.fifo_crdt = 3'd4; bus.fifo_crdt_gnt = 1'b1;
    bus.req_vld = 4'b0001; bus.req_cnt = pack(2, 0, 0, 0);
    exp_q.push_back({4'b0001, 2'd2});
    mid(); check("t1_req_t0", bus.fifo_crdt_req, 0);
    cyc_start(); mid();
    check("t1_req_t1", bus.fifo_crdt_req, 1);
    check("t1_cnt_t1", bus.fifo_crdt_req_cnt, 2);
    check("t1_gnt_t1", bus.req_gnt, 4'b0001);
    check("t1_outstd_t1", outstd_of(0), 0);
    cyc_start(); bus.req_vld = '0; mid();
    check("t1_outstd_t2", outstd_of(0), 2);
    check("t1_req_t2", bus.fifo_crdt_req, 0);
    // Over-consume: clamp to zero and flag.
    cyc_start(); bus.cons_vld = 4'b0001; bus.cons_cnt = pack(3, 0, 0, 0); mid();
    check("t1_undf_before", dut.err_undf, 0);
    cyc_start(); bus.cons_vld = '0; mid();
    check("t1_undf_outstd", outstd_of(0), 0);
    check("t1_undf_flag", dut.err_undf, 1);

    // Round robin with all four requesting one credit.
    apply_reset();
    bus.fifo_crdt = 3'd7; bus.fifo_crdt_gnt = 1'b1;
    bus.req_vld = 4'b1111; bus.req_cnt = pack(1, 1, 1, 1);
    exp_q.push_back({4'b0001, 2'd1});
    exp_q.push_back({4'b0010, 2'd1});
    exp_q.push_back({4'b0100, 2'd1});
    exp_q.push_back({4'b1000, 2'd1});
    exp_q.push_back({4'b0001, 2'd1});
    for (int k = 0; k < 10; k++) begin
      mid();
      e_gnt = (k % 2 == 1) ? (4'b0001 << (((k - 1) / 2) % 4)) : 4'b0000;
      check("rr_gnt", bus.req_gnt, e_gnt);
      if (k < 9) cyc_start();
    end
    cyc_start(); bus.req_vld = '0; mid();
    check("rr_outstd0", outstd_of(0), 2);
    check("rr_outstd3", outstd_of(3), 1);

    // Credit shortage then relief.
    apply_reset();
    bus.fifo_crdt = 3'd1; bus.fifo_crdt_gnt = 1'b1;
    bus.req_vld = 4'b0010; bus.req_cnt = pack(0, 2, 0, 0);
    repeat (3) begin
      mid(); check("cr_blocked", bus.fifo_crdt_req, 0);
      cyc_start();
    end
    bus.fifo_crdt = 3'd2;
    exp_q.push_back({4'b0010, 2'd2});
    mid(); check("cr_arb_cycle", bus.fifo_crdt_req, 0);
    cyc_start(); mid();
    check("cr_req", bus.fifo_crdt_req, 1);
    check("cr_cnt", bus.fifo_crdt_req_cnt, 2);
    cyc_start(); bus.req_vld = '0;

    // Outstanding cap on requester 2.
    apply_reset();
    bus.fifo_crdt = 3'd7; bus.fifo_crdt_gnt = 1'b1;
    bus.req_vld = 4'b0100; bus.req_cnt = pack(0, 0, 3, 0);
    exp_q.push_back({4'b0100, 2'd3});
    cyc_start();
    cyc_start(); bus.req_cnt = pack(0, 0, 2, 0);
    repeat (3) begin
      mid();
      check("cap_blocked", bus.fifo_crdt_req, 0);
      check("cap_outstd3", outstd_of(2), 3);
      cyc_start();
    end
    bus.cons_vld = 4'b0100; bus.cons_cnt = pack(0, 0, 1, 0);
    mid(); check("cap_cons_cycle", bus.fifo_crdt_req, 0);
    cyc_start(); bus.cons_vld = '0;
    exp_q.push_back({4'b0100, 2'd2});
    mid();
    check("cap_outstd2", outstd_of(2), 2);
    check("cap_arb", bus.fifo_crdt_req, 0);
    cyc_start(); mid();
    check("cap_req", bus.fifo_crdt_req, 1);
    check("cap_cnt", bus.fifo_crdt_req_cnt, 2);
    cyc_start(); bus.req_vld = '0; mid();
    check("cap_outstd4", outstd_of(2), 4);

    // FIFO holds the grant off for five cycles.
    apply_reset();
    bus.fifo_crdt = 3'd7; bus.fifo_crdt_gnt = 1'b0;
    bus.req_vld = 4'b0010; bus.req_cnt = pack(0, 3, 0, 0);
    mid(); check("ho_req_t0", bus.fifo_crdt_req, 0);
    repeat (5) begin
      cyc_start(); mid();
      check("ho_req", bus.fifo_crdt_req, 1);
      check("ho_cnt", bus.fifo_crdt_req_cnt, 3);
      check("ho_no_gnt", bus.req_gnt, 0);
      check("ho_rr_ptr", dut.rr_ptr, 0);
    end
    cyc_start(); bus.fifo_crdt_gnt = 1'b1;
    exp_q.push_back({4'b0010, 2'd3});
    mid(); check("ho_gnt", bus.req_gnt, 4'b0010);
    cyc_start(); bus.req_vld = '0; mid();
    check("ho_rr_after", dut.rr_ptr, 2);
    check("ho_outstd1", outstd_of(1), 3);

    // Same-cycle grant and consume on requester 3, then reset during ISSUE.
    apply_reset();
    bus.fifo_crdt = 3'd7; bus.fifo_crdt_gnt = 1'b1;
    bus.req_vld = 4'b1000; bus.req_cnt = pack(0, 0, 0, 1);
    exp_q.push_back({4'b1000, 2'd1});
    cyc_start();
    cyc_start(); bus.req_cnt = pack(0, 0, 0, 2);
    exp_q.push_back({4'b1000, 2'd2});
    mid(); check("sim_outstd_pre", outstd_of(3), 1);
    cyc_start(); bus.cons_vld = 4'b1000; bus.cons_cnt = pack(0, 0, 0, 1);
    mid();
    check("sim_outstd_evt", outstd_of(3), 1);
    check("sim_gnt", bus.req_gnt, 4'b1000);
    cyc_start();
    bus.cons_vld = '0; bus.fifo_crdt_gnt = 1'b0;
    bus.req_vld = 4'b0001; bus.req_cnt = pack(1, 0, 0, 0);
    mid();
    check("sim_outstd_post", outstd_of(3), 2);
    check("sim_arb", bus.fifo_crdt_req, 0);
    cyc_start(); mid();
    check("rst_mid_pre", bus.fifo_crdt_req, 1);
    #1;
    bus.fifo_crdt_gnt = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", bus.fifo_crdt_req, 0);
    check("rst_mid_cnt", bus.fifo_crdt_req_cnt, 0);
    check("rst_mid_gnt", bus.req_gnt, 0);
    check("rst_mid_outstd", outstd, 0);
    idle_inputs();
    repeat (2) @(posedge clk);
    mid();

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
